// File: rtl/sa_result_drain_if.sv
// Result-vector and output-stream signals between SA_CORE, sa_result_drain and the writeback logic.
// slave is the drain block's view; master is the core/consumer side that drives it.
interface sa_result_drain_if #(
    parameter int ROWS = 8,
    parameter int DW   = 32
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [ROWS-1:0][DW-1:0] rdata_in;
    logic [ROWS-1:0]         rvalid_in;
    logic                    outread;
    logic                    m_valid;
    logic                    m_ready;
    logic [DW-1:0]           m_data;
    logic [RW-1:0]           m_row;
    logic                    m_last;

    modport master (
        output rdata_in, rvalid_in, m_ready,
        input  outread, m_valid, m_data, m_row, m_last
    );

    modport slave (
        input  rdata_in, rvalid_in, m_ready,
        output outread, m_valid, m_data, m_row, m_last
    );
endinterface

// File: rtl/sa_result_drain.sv
// Ping-pong result drain: captures whole result vectors from the core and streams them row by row.
// Define SA_DRAIN_STALLCNT_EN to add the saturating stall_cnt output.
module sa_result_drain #(
    parameter int ROWS = 8,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    sa_result_drain_if.slave     bus
`ifdef SA_DRAIN_STALLCNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    bank_state_e             bank_q [2];
    bank_state_e             bank_d [2];
    logic [ROWS-1:0][DW-1:0] mem_q  [2];
    logic                    wr_sel_q, wr_sel_d;
    logic                    rd_sel_q, rd_sel_d;
    logic                    outread_q;
    logic                    m_valid_q, m_valid_d;
    logic [DW-1:0]           m_data_q, m_data_d;
    logic [RW-1:0]           m_row_q, m_row_d;
    logic                    m_last_q, m_last_d;

    logic          all_valid, any_empty, both_empty;
    logic          capture, cap_bank;
    logic          fire, fire_last;
    logic          want_first, head, head_cap;
    logic [RW-1:0] next_row;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        all_valid  = &bus.rvalid_in;
        any_empty  = (bank_q[0] == BANK_EMPTY) || (bank_q[1] == BANK_EMPTY);
        both_empty = (bank_q[0] == BANK_EMPTY) && (bank_q[1] == BANK_EMPTY);
        // outread_q low is what stops the still-presented vector being captured twice.
        capture    = all_valid && any_empty && !outread_q;
        cap_bank   = both_empty ? 1'b0 : wr_sel_q;
        fire       = m_valid_q && bus.m_ready;
        fire_last  = fire && m_last_q;
        next_row   = m_row_q + 1'b1;

        bank_d[0]  = bank_q[0];
        bank_d[1]  = bank_q[1];
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_row_d    = m_row_q;
        m_last_d   = m_last_q;
        want_first = 1'b0;
        head       = rd_sel_q;
        head_cap   = 1'b0;

        if (capture) begin
            bank_d[cap_bank] = BANK_FULL;
            wr_sel_d         = ~cap_bank;
        end

        if (fire_last) begin
            bank_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d         = ~rd_sel_q;
            head             = ~rd_sel_q;
            m_valid_d        = 1'b0;
            want_first       = 1'b1;
        end else if (fire) begin
            m_row_d  = next_row;
            m_data_d = mem_q[rd_sel_q][next_row];
            m_last_d = (next_row == LAST_ROW);
        end else if (!m_valid_q) begin
            head       = both_empty ? 1'b0 : rd_sel_q;
            rd_sel_d   = head;
            want_first = 1'b1;
        end

        // A bank captured this very cycle feeds row 0 straight from the core: no bubble between banks.
        head_cap = capture && (cap_bank == head);
        if (want_first && (bank_q[head] == BANK_FULL || head_cap)) begin
            bank_d[head] = BANK_DRAINING;
            m_valid_d    = 1'b1;
            m_row_d      = '0;
            m_last_d     = 1'b0;
            m_data_d     = head_cap ? bus.rdata_in[0] : mem_q[head][0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            outread_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_row_q   <= '0;
            m_last_q  <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            outread_q <= capture;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_row_q   <= m_row_d;
            m_last_q  <= m_last_d;
        end
    end

    // NOTE: the vector store is not reset; bank state alone decides whether its contents are live.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[cap_bank] <= bus.rdata_in;
        end
    end

    assign bus.outread = outread_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_row   = m_row_q;
    assign bus.m_last  = m_last_q;

`ifdef SA_DRAIN_STALLCNT_EN
    logic [15:0] stall_cnt_q;

    // Counts cycles where the core offers a vector but both banks are occupied.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else if (all_valid && !outread_q && !any_empty && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: reset, single drain, backpressure, ping-pong overflow,
// partial valid, coincident capture/last transfer and mid-drain reset.
module tb_sa_result_drain;

    localparam int ROWS = 8;
    localparam int DW   = 32;
    localparam int RW   = $clog2(ROWS);

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    sa_result_drain_if #(.ROWS(ROWS), .DW(DW)) bus ();

`ifdef SA_DRAIN_STALLCNT_EN
    logic [15:0] stall_cnt;
`endif

    sa_result_drain #(.ROWS(ROWS), .DW(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus)
`ifdef SA_DRAIN_STALLCNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_vec(input int base);
        for (int r = 0; r < ROWS; r++) bus.rdata_in[r] = DW'(base + r);
        bus.rvalid_in = '1;
    endtask

    task automatic clr_vec();
        bus.rvalid_in = '0;
        bus.rdata_in  = '0;
    endtask

    // {m_valid, m_last, m_row, m_data} expected for a valid word.
    function automatic logic [RW+DW+1:0] exp_word(input int val, input int row);
        logic [RW-1:0] rw;
        logic [DW-1:0] dv;
        rw = RW'(row);
        dv = DW'(val);
        return {1'b1, (row == ROWS - 1), rw, dv};
    endfunction

    function automatic logic [RW+DW+1:0] obs_word();
        return {bus.m_valid, bus.m_last, bus.m_row, bus.m_data};
    endfunction

    task automatic test_reset();
        bus.m_ready = 1'b0;
        clr_vec();
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (obs_word() !== '0 || bus.outread !== 1'b0) begin n_bad++; $display("FAIL reset_outputs: got word=%h outread=%b want all zero", obs_word(), bus.outread); end
`ifdef SA_DRAIN_STALLCNT_EN
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        tick(); tick();
        rstn = 1'b1;
        tick(); tick();
        n_cmp++; if (obs_word() !== '0 || bus.outread !== 1'b0) begin n_bad++; $display("FAIL reset_idle: got word=%h outread=%b want all zero", obs_word(), bus.outread); end
    endtask

    task automatic test_single();
        bus.m_ready = 1'b1;
        set_vec(100);
        tick();
        n_cmp++; if (bus.outread !== 1'b1) begin n_bad++; $display("FAIL single_outread_n1: got %b want 1", bus.outread); end
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++; if (obs_word() !== exp_word(100 + r, r)) begin n_bad++; $display("FAIL single_word%0d: got %h want %h", r, obs_word(), exp_word(100 + r, r)); end
            if (r > 0) begin
                n_cmp++; if (bus.outread !== 1'b0) begin n_bad++; $display("FAIL single_outread_pulse%0d: got %b want 0", r, bus.outread); end
            end
            if (r == 1) clr_vec();
            tick();
        end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle_after: got m_valid=%b want 0", bus.m_valid); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int idx, p, pulses;
        logic drop;
        pat = 4'b1001;
        idx = 0; p = 0; pulses = 0; drop = 1'b0;
        bus.m_ready = 1'b0;
        set_vec(200);
        for (int c = 0; c < 40 && idx < ROWS; c++) begin
            tick();
            if (drop) begin clr_vec(); drop = 1'b0; end
            if (bus.outread) begin pulses++; drop = 1'b1; end
            if (bus.m_valid) begin
                n_cmp++; if (obs_word() !== exp_word(200 + idx, idx)) begin n_bad++; $display("FAIL bp_word%0d_cyc%0d: got %h want %h", idx, c, obs_word(), exp_word(200 + idx, idx)); end
            end
            bus.m_ready = pat[p % 4];
            p++;
            if (bus.m_valid && bus.m_ready) idx++;
        end
        bus.m_ready = 1'b1;
        tick();
        n_cmp++; if (idx !== ROWS) begin n_bad++; $display("FAIL bp_word_count: got %0d want %0d", idx, ROWS); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL bp_outread_pulses: got %0d want 1", pulses); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle_after: got m_valid=%b want 0", bus.m_valid); end
    endtask

    task automatic test_three_vectors();
        int base [3];
        int v, pulses, idx, bubbles;
        logic adv;
`ifdef SA_DRAIN_STALLCNT_EN
        logic [15:0] stall0;
        stall0 = stall_cnt;
`endif
        base[0] = 300; base[1] = 400; base[2] = 500;
        v = 0; pulses = 0; adv = 1'b0;
        bus.m_ready = 1'b0;
        set_vec(base[0]);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (adv) begin adv = 1'b0; v++; if (v < 3) set_vec(base[v]); else clr_vec(); end
            if (bus.outread) begin pulses++; adv = 1'b1; end
        end
        n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL three_held_pulses: got %0d want 2", pulses); end
        n_cmp++; if (obs_word() !== exp_word(300, 0)) begin n_bad++; $display("FAIL three_held_word: got %h want %h", obs_word(), exp_word(300, 0)); end
        n_cmp++; if (bus.rvalid_in !== '1 || bus.outread !== 1'b0) begin n_bad++; $display("FAIL three_third_unacked: got rvalid=%h outread=%b want ff/0", bus.rvalid_in, bus.outread); end
`ifdef SA_DRAIN_STALLCNT_EN
        n_cmp++; if (stall_cnt - stall0 !== 16'd8) begin n_bad++; $display("FAIL three_stall_cnt: got delta %0d want 8", stall_cnt - stall0); end
`endif
        bus.m_ready = 1'b1;
        idx = 0; bubbles = 0;
        for (int c = 0; c < 40 && idx < 3 * ROWS; c++) begin
            if (bus.m_valid) begin
                n_cmp++; if (obs_word() !== exp_word(base[idx / ROWS] + idx % ROWS, idx % ROWS)) begin n_bad++; $display("FAIL three_word%0d: got %h want %h", idx, obs_word(), exp_word(base[idx / ROWS] + idx % ROWS, idx % ROWS)); end
                idx++;
            end else begin
                bubbles++;
            end
            tick();
            if (adv) begin adv = 1'b0; v++; if (v < 3) set_vec(base[v]); else clr_vec(); end
            if (bus.outread) begin pulses++; adv = 1'b1; end
        end
        n_cmp++; if (idx !== 3 * ROWS) begin n_bad++; $display("FAIL three_word_count: got %0d want %0d", idx, 3 * ROWS); end
        n_cmp++; if (bubbles !== 0) begin n_bad++; $display("FAIL three_bubbles: got %0d want 0", bubbles); end
        n_cmp++; if (pulses !== 3) begin n_bad++; $display("FAIL three_total_pulses: got %0d want 3", pulses); end
        tick();
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL three_idle_after: got m_valid=%b want 0", bus.m_valid); end
    endtask

    task automatic test_partial();
        int bad;
        bad = 0;
        bus.m_ready = 1'b1;
        set_vec(600);
        bus.rvalid_in = {1'b0, {(ROWS - 1){1'b1}}};
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.outread !== 1'b0 || bus.m_valid !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL partial_no_capture: got %0d active cycles want 0", bad); end
        bus.rvalid_in[ROWS-1] = 1'b1;
        tick();
        n_cmp++; if (bus.outread !== 1'b1) begin n_bad++; $display("FAIL partial_outread: got %b want 1", bus.outread); end
        n_cmp++; if (obs_word() !== exp_word(600, 0)) begin n_bad++; $display("FAIL partial_word0: got %h want %h", obs_word(), exp_word(600, 0)); end
        for (int r = 1; r < ROWS; r++) begin
            tick();
            if (r == 1) clr_vec();
            n_cmp++; if (obs_word() !== exp_word(600 + r, r)) begin n_bad++; $display("FAIL partial_word%0d: got %h want %h", r, obs_word(), exp_word(600 + r, r)); end
        end
        tick();
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL partial_idle_after: got m_valid=%b want 0", bus.m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [RW+DW+1:0] exp;
        bus.m_ready = 1'b1;
        set_vec(700);
        for (int k = 1; k <= 2 * ROWS; k++) begin
            tick();
            if (k == 2) clr_vec();
            if (k == ROWS) set_vec(800);
            if (k == ROWS + 2) clr_vec();
            exp = (k <= ROWS) ? exp_word(700 + k - 1, k - 1) : exp_word(800 + k - ROWS - 1, k - ROWS - 1);
            n_cmp++; if (obs_word() !== exp) begin n_bad++; $display("FAIL b2b_word_k%0d: got %h want %h", k, obs_word(), exp); end
            n_cmp++; if (bus.outread !== (k == 1 || k == ROWS + 1)) begin n_bad++; $display("FAIL b2b_outread_k%0d: got %b want %b", k, bus.outread, (k == 1 || k == ROWS + 1)); end
        end
        tick();
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after: got m_valid=%b want 0", bus.m_valid); end
    endtask

    task automatic test_reset_mid();
        bus.m_ready = 1'b1;
        set_vec(900);
        tick(); tick();
        clr_vec();
        tick();
        n_cmp++; if (obs_word() !== exp_word(902, 2)) begin n_bad++; $display("FAIL rstmid_pre_word: got %h want %h", obs_word(), exp_word(902, 2)); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (obs_word() !== '0 || bus.outread !== 1'b0) begin n_bad++; $display("FAIL rstmid_async_clear: got word=%h outread=%b want all zero", obs_word(), bus.outread); end
`ifdef SA_DRAIN_STALLCNT_EN
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        tick();
        rstn = 1'b1;
        tick();
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_stale: got m_valid=%b want 0", bus.m_valid); end
        set_vec(1000);
        tick();
        n_cmp++; if (bus.outread !== 1'b1) begin n_bad++; $display("FAIL rstmid_outread: got %b want 1", bus.outread); end
        for (int r = 0; r < ROWS; r++) begin
            if (r == 1) clr_vec();
            n_cmp++; if (obs_word() !== exp_word(1000 + r, r)) begin n_bad++; $display("FAIL rstmid_word%0d: got %h want %h", r, obs_word(), exp_word(1000 + r, r)); end
            tick();
        end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle_after: got m_valid=%b want 0", bus.m_valid); end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        clr_vec();
        test_reset();
        test_single();
        test_backpressure();
        test_three_vectors();
        test_partial();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
